scan_chain_loader: RTL and testbench
====================================

Name: scan_chain_loader

Overview:
- Upstream driver for the configuration scan chain.
- Accepts configuration words from the host/top-level controller over a valid/ready handshake and serialises them, LSB first, onto the chain's scan-input and scan-enable lines.
- Shifts exactly CHAIN_LEN bits, then flags completion. While shifting, the chain's parallel config outputs are forced low; after completion, the downstream config is valid.

Parameters:
- CHAIN_LEN, 40: total scan flip-flops in the chain, i.e. bits shifted per load. Must be ≥ 1.
- WORD_W, 16: width of each host configuration word. Must be ≥ 1.

Ports:
- clk  input  1  system clock; all logic here on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  single-cycle request to begin a chain load; honoured only in IDLE.
- in_data  input  WORD_W  configuration word; bit 0 is shifted first.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader can accept a word.
- scan_en  output  1  to chain se.
- scan_in  output  1  to chain si (first FF).
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle pulse after the final bit is shifted.
- cfg_loaded  output  1  chain holds a complete configuration.
- bits_left  output  $clog2(CHAIN_LEN+1)  bits still to shift.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - scan_en=0, scan_in=0, in_ready=0, busy=0, done=0, cfg_loaded=0, bits_left=0.
  - Shift register and counters are cleared.
  - Reset mid-load abandons the load. The chain keeps whatever partial content it has; cfg_loaded stays 0.
- States: IDLE, WAIT_WORD, SHIFT, DONE.
- IDLE:
  - scan_en=0, in_ready=0.
  - start=1 → WAIT_WORD next cycle, with bits_left=CHAIN_LEN, busy=1 and cfg_loaded=0.
  - start while not in IDLE is ignored.
- WAIT_WORD:
  - in_ready=1, scan_en=0 (chain holds).
  - On in_valid & in_ready: load in_data into the shift register and set word_cnt = min(WORD_W, bits_left). Move to SHIFT next cycle.
- SHIFT:
  - in_ready=0.
  - Each cycle: scan_en=1, scan_in=sreg[0], sreg shifts right by 1, word_cnt decrements, bits_left decrements.
  - Exits on the cycle the last bit is presented. If bits_left reaches 0 → DONE; else if word_cnt reaches 0 → WAIT_WORD.
- DONE:
  - One cycle with done=1, busy=0, cfg_loaded=1, scan_en=0.
  - Then → IDLE.
- Timing:
  - scan_en and scan_in are registered outputs, updated on rising clk.
  - The chain captures on falling clk, so each cycle with scan_en=1 moves exactly one bit, half a cycle after launch.
- Exact-count invariant: the total number of cycles with scan_en=1 per load equals CHAIN_LEN.
- Partial last word: if CHAIN_LEN is not a multiple of WORD_W, only the low (CHAIN_LEN mod WORD_W) bits of the final word are shifted. The upper bits are discarded.
- Throughput: one bubble cycle (WAIT_WORD) per word minimum. Host stalls extend WAIT_WORD with scan_en=0, so no bit is lost or duplicated.
- Bit placement: the first bit shifted ends in the last flip-flop of the chain. The final bit shifted ends in the first.
- Idle outputs: scan_in is 0 whenever scan_en=0.

Test Plan:
- Full load, CHAIN_LEN=40, WORD_W=16, words 0xA5C3, 0x0F0F, 0x00FF with no stalls:
  - scan_en high for exactly 40 cycles.
  - Serial stream = 0xA5C3 LSB-first, then 0x0F0F, then low 8 bits of 0x00FF.
  - done pulses once; cfg_loaded=1; a 40-FF chain model reads back the expected pattern.
- Host stall: hold in_valid=0 for 5 cycles before word 2:
  - scan_en=0 and in_ready=1 throughout the stall.
  - Chain contents unchanged during the stall; final result matches the no-stall case.
- start during busy: pulse start while in SHIFT:
  - Ignored; bits_left continues its decrement; exactly one done pulse.
- Reset mid-load: assert reset after 20 shifted bits:
  - scan_en=0 immediately (asynchronous); busy=0, cfg_loaded=0.
  - A fresh start then performs a full 40-bit load correctly.
- CHAIN_LEN=16=WORD_W, single word 0x8001:
  - Exactly 16 shift cycles, no second WAIT_WORD, done one cycle after the last bit.
- Back-to-back loads: start in the cycle after DONE:
  - cfg_loaded clears on acceptance; the second load is independent and correct.

Source files
------------

// File: rtl/scan_chain_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// scan_chain_loader : serialises host config words LSB-first onto a scan chain,
//                     shifting exactly CHAIN_LEN bits per load.  Rev 1.0
// ---------------------------------------------------------------------------
module scan_chain_loader #(
   parameter int CHAIN_LEN = 40,
   parameter int WORD_W    = 16
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic [WORD_W-1:0]              in_data,
   input  logic                           in_valid,
   output logic                           in_ready,
   output logic                           scan_en,
   output logic                           scan_in,
   output logic                           busy,
   output logic                           done,
   output logic                           cfg_loaded,
   output logic [$clog2(CHAIN_LEN+1)-1:0] bits_left
);

   localparam int BL_W = $clog2(CHAIN_LEN + 1);
   localparam int WC_W = $clog2(WORD_W + 1);

   localparam logic [BL_W-1:0] BL_ONE  = BL_W'(1);
   localparam logic [BL_W-1:0] BL_FULL = BL_W'(CHAIN_LEN);
   localparam logic [WC_W-1:0] WC_ONE  = WC_W'(1);
   localparam logic [WC_W-1:0] WC_FULL = WC_W'(WORD_W);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_WORD = 2'd1,
      ST_SHIFT     = 2'd2,
      ST_DONE      = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [WORD_W-1:0] sreg_q, sreg_d;
   logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
   logic [BL_W-1:0]   bits_left_q, bits_left_d;
   logic              scan_en_q, scan_en_d;
   logic              scan_in_q, scan_in_d;
   logic              cfg_loaded_q, cfg_loaded_d;
   logic [WC_W-1:0]   first_cnt;

   // Bits taken from a freshly accepted word: a whole word, or the remainder
   // of the chain when fewer than WORD_W bits are still outstanding.
   always_comb begin
      first_cnt = WC_FULL;
      if (32'(bits_left_q) < WORD_W) begin
         first_cnt = WC_W'(bits_left_q);
      end
   end

   always_comb begin
      state_d      = state_q;
      sreg_d       = sreg_q;
      word_cnt_d   = word_cnt_q;
      bits_left_d  = bits_left_q;
      scan_en_d    = 1'b0;
      scan_in_d    = 1'b0;
      cfg_loaded_d = cfg_loaded_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d      = ST_WAIT_WORD;
               bits_left_d  = BL_FULL;
               cfg_loaded_d = 1'b0;
            end
         end

         // The first bit is launched on the acceptance edge so that every
         // SHIFT cycle presents exactly one bit.
         ST_WAIT_WORD: begin
            if (in_valid) begin
               state_d    = ST_SHIFT;
               scan_en_d  = 1'b1;
               scan_in_d  = in_data[0];
               sreg_d     = in_data >> 1;
               word_cnt_d = first_cnt;
            end
         end

         ST_SHIFT: begin
            bits_left_d = bits_left_q - BL_ONE;
            word_cnt_d  = word_cnt_q - WC_ONE;
            if (bits_left_q == BL_ONE) begin
               state_d      = ST_DONE;
               cfg_loaded_d = 1'b1;
            end else if (word_cnt_q == WC_ONE) begin
               state_d = ST_WAIT_WORD;
            end else begin
               scan_en_d = 1'b1;
               scan_in_d = sreg_q[0];
               sreg_d    = sreg_q >> 1;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         sreg_q       <= '0;
         word_cnt_q   <= '0;
         bits_left_q  <= '0;
         scan_en_q    <= 1'b0;
         scan_in_q    <= 1'b0;
         cfg_loaded_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         sreg_q       <= sreg_d;
         word_cnt_q   <= word_cnt_d;
         bits_left_q  <= bits_left_d;
         scan_en_q    <= scan_en_d;
         scan_in_q    <= scan_in_d;
         cfg_loaded_q <= cfg_loaded_d;
      end
   end

   assign in_ready   = (state_q == ST_WAIT_WORD);
   assign busy       = (state_q == ST_WAIT_WORD) || (state_q == ST_SHIFT);
   assign done       = (state_q == ST_DONE);
   assign scan_en    = scan_en_q;
   assign scan_in    = scan_in_q;
   assign cfg_loaded = cfg_loaded_q;
   assign bits_left  = bits_left_q;

endmodule
`default_nettype wire

// File: tb/tb_scan_chain_loader.sv
`default_nettype none
// tb_scan_chain_loader : two loaders (40/16 and 16/16) checked cycle by cycle
// against a bit-queue model, plus literal chain images after each load.
module tb_scan_chain_loader;

   logic        clk = 1'b0;
   logic [1:0]  rstn = 2'b00;
   logic [1:0]  st = 2'b00;
   logic [1:0]  vld = 2'b00;
   logic [15:0] dat [2];
   logic [1:0]  rdy, se, si, bsy, dn_o, cfg;
   logic [5:0]  bl0;
   logic [4:0]  bl1;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   scan_chain_loader #(.CHAIN_LEN(40), .WORD_W(16)) u_a (
      .clk(clk), .reset(rstn[0]), .start(st[0]), .in_data(dat[0]), .in_valid(vld[0]),
      .in_ready(rdy[0]), .scan_en(se[0]), .scan_in(si[0]), .busy(bsy[0]),
      .done(dn_o[0]), .cfg_loaded(cfg[0]), .bits_left(bl0));

   scan_chain_loader #(.CHAIN_LEN(16), .WORD_W(16)) u_b (
      .clk(clk), .reset(rstn[1]), .start(st[1]), .in_data(dat[1]), .in_valid(vld[1]),
      .in_ready(rdy[1]), .scan_en(se[1]), .scan_in(si[1]), .busy(bsy[1]),
      .done(dn_o[1]), .cfg_loaded(cfg[1]), .bits_left(bl1));

   // ---------------- behavioural model (one per loader) ----------------
   // A load is: CHAIN_LEN bits, delivered word by word; each accepted word
   // contributes min(16, remaining) bits, one per cycle, the next cycle on.
   bit        m_act [2];
   bit        m_cv  [2];
   bit        m_cb  [2];
   bit [15:0] m_pend[2];
   int        m_pc  [2];
   int        m_sh  [2];
   bit        m_dn  [2];
   bit        m_ld  [2];

   function automatic int chain_len(input int d);
      return (d == 0) ? 40 : 16;
   endfunction

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (!rstn[d]) begin
            m_act[d] = 0; m_cv[d] = 0; m_cb[d] = 0; m_pend[d] = '0;
            m_pc[d] = 0; m_sh[d] = 0; m_dn[d] = 0; m_ld[d] = 0;
         end else begin
            bit idle, ready;
            int n;
            idle  = !m_act[d] && !m_dn[d];
            ready = m_act[d] && !m_cv[d] && (m_pc[d] == 0);
            m_dn[d] = 0;
            if (m_cv[d]) begin
               m_sh[d]++;
               if (m_pc[d] > 0) begin
                  m_cb[d] = m_pend[d][0];
                  m_pend[d] = m_pend[d] >> 1;
                  m_pc[d]--;
               end else begin
                  m_cv[d] = 0;
                  m_cb[d] = 0;
                  if (m_sh[d] == chain_len(d)) begin
                     m_act[d] = 0; m_dn[d] = 1; m_ld[d] = 1;
                  end
               end
            end else if (ready && vld[d]) begin
               n = chain_len(d) - m_sh[d];
               if (n > 16) n = 16;
               m_cv[d] = 1;
               m_cb[d] = dat[d][0];
               m_pend[d] = dat[d] >> 1;
               m_pc[d] = n - 1;
            end
            if (idle && st[d]) begin
               m_act[d] = 1; m_sh[d] = 0; m_ld[d] = 0;
            end
         end
      end
   end

   // ---------------- checking ----------------
   logic [39:0] ch0 = '0;
   logic [15:0] ch1 = '0;
   int          obs_sh[2];
   int          dcnt[2];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            if (rstn[d]) begin
               int bl;
               bl = (d == 0) ? int'(bl0) : int'(bl1);
               chk($sformatf("dut%0d.scan_en", d), 64'(se[d]), 64'(m_cv[d]));
               chk($sformatf("dut%0d.scan_in", d), 64'(si[d]), 64'(m_cv[d] & m_cb[d]));
               chk($sformatf("dut%0d.in_ready", d), 64'(rdy[d]),
                   64'(m_act[d] && !m_cv[d] && m_pc[d] == 0));
               chk($sformatf("dut%0d.busy", d), 64'(bsy[d]), 64'(m_act[d]));
               chk($sformatf("dut%0d.done", d), 64'(dn_o[d]), 64'(m_dn[d]));
               chk($sformatf("dut%0d.cfg_loaded", d), 64'(cfg[d]), 64'(m_ld[d]));
               chk($sformatf("dut%0d.bits_left", d), 64'(bl),
                   64'(m_act[d] ? chain_len(d) - m_sh[d] : 0));
            end
         end
         if (se[0]) ch0 = {ch0[38:0], si[0]};
         if (se[1]) ch1 = {ch1[14:0], si[1]};
         for (int d = 0; d < 2; d++) begin
            if (!rstn[d]) begin
               obs_sh[d] = 0;
            end else begin
               if (se[d]) obs_sh[d]++;
               if (dn_o[d]) begin
                  chk($sformatf("dut%0d.shifts_per_load", d), 64'(obs_sh[d]), 64'(chain_len(d)));
                  obs_sh[d] = 0;
                  dcnt[d]++;
               end
            end
         end
      end
   endtask

   // ---------------- stimulus ----------------
   task automatic pulse_start(input int d);
      @(negedge clk); #2 st[d] = 1'b1;
      @(negedge clk); #2 st[d] = 1'b0;
   endtask

   task automatic send_word(input int d, input logic [15:0] w, input int stall);
      bit got;
      logic [39:0] snap;
      got = 0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk); #1;
         if (rdy[d]) got = 1;
      end
      if (!got) begin
         chk("in_ready_timeout", 64'(0), 64'(1));
         return;
      end
      snap = ch0;
      for (int i = 0; i < stall; i++) begin
         @(negedge clk); #1;
         chk("stall.in_ready", 64'(rdy[d]), 64'(1));
         chk("stall.scan_en", 64'(se[d]), 64'(0));
      end
      if (stall > 0) chk("stall.chain_hold", 64'(ch0), 64'(snap));
      #1 vld[d] = 1'b1; dat[d] = w;
      @(negedge clk); #2 vld[d] = 1'b0; dat[d] = '0;
   endtask

   task automatic wait_done(input int d);
      bit seen;
      seen = 0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(negedge clk); #1;
         if (dn_o[d]) seen = 1;
      end
      if (!seen) chk("done_timeout", 64'(0), 64'(1));
   endtask

   task automatic load_a(input logic [15:0] w0, input logic [15:0] w1,
                         input logic [15:0] w2, input int stall1, input bit poke);
      send_word(0, w0, 0);
      if (poke) pulse_start(0);
      send_word(0, w1, stall1);
      send_word(0, w2, 0);
      wait_done(0);
   endtask

   initial begin
      int  d0;
      bit  got;
      dat[0] = '0;
      dat[1] = '0;
      fork
         monitor();
      join_none

      repeat (2) @(negedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         chk("reset.scan_en", 64'(se[d]), 64'(0));
         chk("reset.scan_in", 64'(si[d]), 64'(0));
         chk("reset.in_ready", 64'(rdy[d]), 64'(0));
         chk("reset.busy", 64'(bsy[d]), 64'(0));
         chk("reset.done", 64'(dn_o[d]), 64'(0));
         chk("reset.cfg_loaded", 64'(cfg[d]), 64'(0));
      end
      chk("reset.bits_left_a", 64'(bl0), 64'(0));
      #1 rstn = 2'b11;

      // full load, no stalls
      d0 = dcnt[0];
      pulse_start(0);
      @(negedge clk); #1;
      chk("start.bits_left", 64'(bl0), 64'(40));
      chk("start.busy", 64'(bsy[0]), 64'(1));
      load_a(16'hA5C3, 16'h0F0F, 16'h00FF, 0, 0);
      chk("full.cfg_loaded", 64'(cfg[0]), 64'(1));
      chk("full.chain", 64'(ch0), 64'(40'hC3A5F0F0FF));
      repeat (4) @(negedge clk);
      #1 chk("full.done_pulses", 64'(dcnt[0] - d0), 64'(1));

      // host stall before word 2
      pulse_start(0);
      @(negedge clk); #1 chk("restart.cfg_cleared", 64'(cfg[0]), 64'(0));
      load_a(16'hA5C3, 16'h0F0F, 16'h00FF, 5, 0);
      chk("stall.chain", 64'(ch0), 64'(40'hC3A5F0F0FF));

      // start pulsed while shifting
      d0 = dcnt[0];
      pulse_start(0);
      load_a(16'hA5C3, 16'h0F0F, 16'h00FF, 0, 1);
      chk("poke.chain", 64'(ch0), 64'(40'hC3A5F0F0FF));
      repeat (4) @(negedge clk);
      #1 chk("poke.done_pulses", 64'(dcnt[0] - d0), 64'(1));

      // reset after 20 shifted bits
      pulse_start(0);
      send_word(0, 16'h1111, 0);
      send_word(0, 16'h2222, 0);
      got = 0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk); #1;
         if (obs_sh[0] == 20) got = 1;
      end
      chk("midreset.reached_20", 64'(got), 64'(1));
      #1 rstn[0] = 1'b0;
      #1;
      chk("midreset.scan_en", 64'(se[0]), 64'(0));
      chk("midreset.busy", 64'(bsy[0]), 64'(0));
      chk("midreset.cfg_loaded", 64'(cfg[0]), 64'(0));
      chk("midreset.bits_left", 64'(bl0), 64'(0));
      @(negedge clk); #2 rstn[0] = 1'b1;
      pulse_start(0);
      load_a(16'hA5C3, 16'h0F0F, 16'h00FF, 0, 0);
      chk("afterreset.chain", 64'(ch0), 64'(40'hC3A5F0F0FF));

      // back-to-back: start in the cycle right after DONE
      pulse_start(0);
      @(negedge clk); #1 chk("b2b.cfg_cleared", 64'(cfg[0]), 64'(0));
      load_a(16'h1234, 16'h5678, 16'hA55A, 0, 0);
      chk("b2b.chain", 64'(ch0), 64'(40'h2C481E6A5A));

      // single-word chain
      d0 = dcnt[1];
      pulse_start(1);
      send_word(1, 16'h8001, 0);
      wait_done(1);
      chk("short.chain", 64'(ch1), 64'(16'h8001));
      chk("short.cfg_loaded", 64'(cfg[1]), 64'(1));
      repeat (4) @(negedge clk);
      #1 chk("short.done_pulses", 64'(dcnt[1] - d0), 64'(1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
